// File: rtl/chain_score_pkg.sv
// chain_score_pkg: widths, latencies and record types shared by the chain
// scorer and its ilog2 stage.
package chain_score_pkg;

  localparam int POS_W     = 32;  // anchor position width
  localparam int TAG_W     = 16;  // predecessor tag width
  localparam int SCORE_W   = 32;  // signed score width
  localparam int SPAN_W    = 8;   // seed span width
  localparam int Q_FRAC    = 8;   // fraction bits of avg_qspan_q8
  localparam int LIN_W     = 24;  // linear gap penalty width
  localparam int DD_W      = 16;  // dd bits feeding lin and ilog2
  localparam int LOG_W     = 5;   // ilog2 result width for a DD_W input
  localparam int CS_LAT    = 6;   // accept edge to FIFO write edge
  localparam int ILOG2_LAT = 3;   // ilog2 register stages

  // Fields that ride the delay line beside ilog2 (S3..S5).
  typedef struct packed {
    logic [SPAN_W-1:0] base;
    logic [LIN_W-1:0]  lin;
    logic              reject;
    logic [TAG_W-1:0]  tag;
  } cs_dly_t;

  // One buffered result.
  typedef struct packed {
    logic [SCORE_W-1:0] score;
    logic               reject;
    logic [TAG_W-1:0]   tag;
  } cs_res_t;

  function automatic int count_ones(input logic [CS_LAT-1:0] v);
    count_ones = 0;
    for (int i = 0; i < CS_LAT; i++) count_ones += int'(v[i]);
  endfunction

endpackage

// File: rtl/chain_score_ilog2.sv
// ilog2: 3-stage floor(log2(v)) with ilog2(0) = 0.
// Ports:
//   clk, reset         clock, async active-high reset
//   v_valid, v         operand and its valid
//   log2_valid, log2   result and its valid, ILOG2_LAT edges later
module ilog2
  import chain_score_pkg::*;
#(
  parameter int W  = DD_W,
  parameter int OW = LOG_W
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          v_valid,
  input  logic [W-1:0]  v,
  output logic          log2_valid,
  output logic [OW-1:0] log2
);

  logic          a_v_q, b_v_q, c_v_q;
  logic [W-1:0]  a_val_q;
  logic [OW-1:0] b_log_q, c_log_q, b_log_d;

  // Highest set bit wins; an all-zero operand yields 0.
  always_comb begin
    b_log_d = '0;
    for (int i = 0; i < W; i++) begin
      if (a_val_q[i]) b_log_d = OW'(i);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      a_v_q   <= 1'b0;
      b_v_q   <= 1'b0;
      c_v_q   <= 1'b0;
      a_val_q <= '0;
      b_log_q <= '0;
      c_log_q <= '0;
    end else begin
      a_v_q   <= v_valid;
      a_val_q <= v;
      b_v_q   <= a_v_q;
      b_log_q <= b_log_d;
      c_v_q   <= b_v_q;
      c_log_q <= b_log_q;
    end
  end

  assign log2_valid = c_v_q;
  assign log2       = c_log_q;

endmodule

// File: rtl/chain_score.sv
// chain_score: pipelined anchor-pair scorer with credit-controlled output FIFO.
// Ports:
//   clk, reset                      clock, async active-high reset
//   in_valid/in_ready               pair handshake
//   in_ri, in_qi, in_rj, in_qj      successor / predecessor positions
//   in_span, in_tag, avg_qspan_q8   seed span, pass-through tag, Q8.8 avg span
//   out_valid/out_ready             FIFO head handshake
//   out_score, out_reject, out_tag  result at FIFO head
module chain_score
  import chain_score_pkg::*;
#(
  parameter int MAX_DIST_X = 5000,
  parameter int MAX_DIST_Y = 5000,
  parameter int BW         = 500,
  parameter int FIFO_DEPTH = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [POS_W-1:0]   in_ri,
  input  logic [POS_W-1:0]   in_qi,
  input  logic [POS_W-1:0]   in_rj,
  input  logic [POS_W-1:0]   in_qj,
  input  logic [SPAN_W-1:0]  in_span,
  input  logic [TAG_W-1:0]   in_tag,
  input  logic [15:0]        avg_qspan_q8,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [SCORE_W-1:0] out_score,
  output logic               out_reject,
  output logic [TAG_W-1:0]   out_tag
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic signed [POS_W:0] MAX_DQ = (POS_W+1)'(MAX_DIST_X);
  localparam logic signed [POS_W:0] MAX_DR = (POS_W+1)'(MAX_DIST_Y);

  logic accept, push, pop;
  assign accept = in_valid & in_ready;

  // S1: differences and range rejects
  logic                     s1_v_q, s1_rej_q, s1_rej_d;
  logic signed [POS_W:0]    s1_dq_q, s1_dr_q, s1_dq_d, s1_dr_d;
  logic [SPAN_W-1:0]        s1_span_q;
  logic [TAG_W-1:0]         s1_tag_q;
  logic [15:0]              s1_avg_q;

  always_comb begin
    s1_dq_d  = $signed({1'b0, in_qi}) - $signed({1'b0, in_qj});
    s1_dr_d  = $signed({1'b0, in_ri}) - $signed({1'b0, in_rj});
    s1_rej_d = (s1_dq_d <= 0) || (s1_dq_d > MAX_DQ) ||
               (s1_dr_d <= 0) || (s1_dr_d > MAX_DR);
  end

  // S2: band, base, linear penalty
  logic                     s2_v_q, s2_rej_q, s2_rej_d;
  logic signed [POS_W+1:0]  s2_diff;
  logic [POS_W+1:0]         s2_dd_abs;
  logic [DD_W-1:0]          s2_dd_q;
  logic [SPAN_W-1:0]        s2_base_q, s2_base_d;
  logic [LIN_W-1:0]         s2_lin_q, s2_lin_d;
  logic [TAG_W-1:0]         s2_tag_q;

  always_comb begin
    s2_diff   = (POS_W+2)'(s1_dr_q) - (POS_W+2)'(s1_dq_q);
    s2_dd_abs = s2_diff[POS_W+1] ? -s2_diff : s2_diff;
    s2_rej_d  = s1_rej_q | (s2_dd_abs > (POS_W+2)'(BW));
    s2_base_d = (s1_dq_q > $signed((POS_W+1)'(s1_span_q))) ? s1_span_q
                                                           : s1_dq_q[SPAN_W-1:0];
    s2_lin_d  = LIN_W'((32'(s2_dd_abs[DD_W-1:0]) * 32'(s1_avg_q)) >> Q_FRAC);
  end

  // S3..S5: delay line alongside ilog2
  cs_dly_t                  dly_q [ILOG2_LAT];
  logic [ILOG2_LAT-1:0]     dly_v_q;
  logic [LOG_W-1:0]         log2_w;
  logic                     log2_valid_unused;

  ilog2 #(.W(DD_W), .OW(LOG_W)) u_ilog2 (
    .clk        (clk),
    .reset      (reset),
    .v_valid    (s2_v_q),
    .v          (s2_dd_q),
    .log2_valid (log2_valid_unused),
    .log2       (log2_w)
  );

  // S6: final score
  logic                     s6_v_q, s6_rej_q;
  logic [SCORE_W-1:0]       s6_score_q, s6_score_d;
  logic [TAG_W-1:0]         s6_tag_q;

  always_comb begin
    s6_score_d = '0;
    if (!dly_q[ILOG2_LAT-1].reject)
      s6_score_d = SCORE_W'(dly_q[ILOG2_LAT-1].base) - SCORE_W'(dly_q[ILOG2_LAT-1].lin)
                   - SCORE_W'(log2_w >> 1);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s1_v_q  <= 1'b0;
      s2_v_q  <= 1'b0;
      dly_v_q <= '0;
      s6_v_q  <= 1'b0;
    end else begin
      s1_v_q  <= accept;
      s2_v_q  <= s1_v_q;
      dly_v_q <= {dly_v_q[ILOG2_LAT-2:0], s2_v_q};
      s6_v_q  <= dly_v_q[ILOG2_LAT-1];
    end
  end

  // Datapath registers carry don't-care contents when their valid bit is clear.
  always_ff @(posedge clk) begin
    s1_dq_q    <= s1_dq_d;
    s1_dr_q    <= s1_dr_d;
    s1_rej_q   <= s1_rej_d;
    s1_span_q  <= in_span;
    s1_tag_q   <= in_tag;
    s1_avg_q   <= avg_qspan_q8;
    s2_dd_q    <= s2_dd_abs[DD_W-1:0];
    s2_rej_q   <= s2_rej_d;
    s2_base_q  <= s2_base_d;
    s2_lin_q   <= s2_lin_d;
    s2_tag_q   <= s1_tag_q;
    dly_q[0]   <= '{base: s2_base_q, lin: s2_lin_q, reject: s2_rej_q, tag: s2_tag_q};
    for (int i = 1; i < ILOG2_LAT; i++) dly_q[i] <= dly_q[i-1];
    s6_score_q <= s6_score_d;
    s6_rej_q   <= dly_q[ILOG2_LAT-1].reject;
    s6_tag_q   <= dly_q[ILOG2_LAT-1].tag;
  end

  // Output FIFO: credit accounting guarantees room for every S6 result.
  cs_res_t                  fifo_q [FIFO_DEPTH];
  logic [PTR_W-1:0]         wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0]         cnt_q, cnt_d;
  cs_res_t                  head;

  assign push = s6_v_q;
  assign pop  = out_valid & out_ready;

  always_comb begin
    cnt_d = cnt_q;
    case ({push, pop})
      2'b10:   cnt_d = cnt_q + 1'b1;
      2'b01:   cnt_d = cnt_q - 1'b1;
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      cnt_q <= cnt_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) fifo_q[wr_ptr_q] <= '{score: s6_score_q, reject: s6_rej_q, tag: s6_tag_q};
  end

  // Stale memory must not leak onto the ports after reset, so the head is gated.
  assign head       = fifo_q[rd_ptr_q];
  assign out_valid  = (cnt_q != '0);
  assign out_score  = out_valid ? head.score  : '0;
  assign out_reject = out_valid ? head.reject : 1'b0;
  assign out_tag    = out_valid ? head.tag    : '0;

  // Credits come from registered state only; a pop this cycle frees a slot next cycle.
  assign in_ready = !reset &&
    ((int'(cnt_q) + count_ones({s6_v_q, dly_v_q, s2_v_q, s1_v_q})) < FIFO_DEPTH);

endmodule

// File: tb/tb_chain_score.sv
module tb_chain_score;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] in_ri = '0, in_qi = '0, in_rj = '0, in_qj = '0;
  logic [7:0]  in_span = '0;
  logic [15:0] in_tag = '0;
  logic [15:0] avg_qspan_q8 = '0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [31:0] out_score;
  logic        out_reject;
  logic [15:0] out_tag;

  chain_score dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_ri(in_ri), .in_qi(in_qi), .in_rj(in_rj), .in_qj(in_qj),
    .in_span(in_span), .in_tag(in_tag), .avg_qspan_q8(avg_qspan_q8),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_score(out_score), .out_reject(out_reject), .out_tag(out_tag)
  );

  always #5 clk = ~clk;

  typedef struct {
    int unsigned ri, qi, rj, qj;
    int unsigned w, avg;
    int          exp_score;
    bit          exp_rej;
  } vec_t;

  typedef struct {
    longint      score;
    bit          rej;
    int unsigned tag;
  } res_t;

  res_t   exp_q[$];
  int     n_chk = 0;
  int     n_fail = 0;
  int     n_out = 0;
  longint prev_out = 0;
  bit     prev_hold = 0;

  task automatic check(input string name, input longint act, input longint exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference scoring straight from the pair rules, in plain integer arithmetic.
  function automatic res_t model(input int unsigned ri, qi, rj, qj, w, avg, tag);
    res_t   r;
    longint dq, dr, dd, base, lin, lg, x;
    dq = longint'(qi) - longint'(qj);
    dr = longint'(ri) - longint'(rj);
    dd = dr - dq;
    if (dd < 0) dd = -dd;
    r.tag = tag;
    r.rej = (dq <= 0) || (dq > 5000) || (dr <= 0) || (dr > 5000) || (dd > 500);
    if (r.rej) r.score = 0;
    else begin
      base = (dq < longint'(w)) ? dq : longint'(w);
      lin  = (((dd % 65536) * longint'(avg)) / 256) % (64'd1 << 24);
      lg = 0;
      x  = dd;
      while (x > 1) begin x = x / 2; lg++; end
      r.score = base - lin - lg / 2;
    end
    return r;
  endfunction

  // Scoreboard, output stability and acceptance capture, all at the falling edge.
  always @(negedge clk) begin
    longint cur;
    res_t   e;
    cur = longint'({out_score, out_reject, out_tag});
    if (reset) begin
      exp_q.delete();
      prev_hold = 0;
    end else begin
      if (prev_hold) check("out_hold_stable", cur, prev_out);
      prev_hold = out_valid && !out_ready;
      prev_out  = cur;
      if (out_valid && out_ready) begin
        n_out++;
        check("sb_expected_available", longint'(exp_q.size() > 0), 1);
        if (exp_q.size() > 0) begin
          e = exp_q.pop_front();
          check("sb_score", longint'($signed(out_score)), e.score);
          check("sb_reject", longint'(out_reject), longint'(e.rej));
          check("sb_tag", longint'(out_tag), longint'(e.tag));
        end
      end
      if (in_valid && in_ready)
        exp_q.push_back(model(in_ri, in_qi, in_rj, in_qj, in_span, avg_qspan_q8, in_tag));
    end
  end

  task automatic drive(input vec_t v, input int unsigned tag);
    in_ri = v.ri; in_qi = v.qi; in_rj = v.rj; in_qj = v.qj;
    in_span = 8'(v.w); avg_qspan_q8 = 16'(v.avg); in_tag = 16'(tag);
  endtask

  function automatic vec_t rnd_pair();
    vec_t v;
    int   dq, dr;
    if ($urandom_range(0, 7) == 0) begin
      v.ri = $urandom; v.qi = $urandom; v.rj = $urandom; v.qj = $urandom;
    end else begin
      dq   = int'($urandom_range(0, 5100));
      dr   = dq + int'($urandom_range(0, 1100)) - 550;
      v.qj = $urandom_range(0, 1000000);
      v.rj = $urandom_range(1000, 1000000);
      v.qi = v.qj + int'(dq);
      v.ri = int'(v.rj) + dr;
    end
    v.w   = $urandom_range(0, 255);
    v.avg = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 65535) : $urandom_range(0, 1023);
    v.exp_score = 0;
    v.exp_rej = 0;
    return v;
  endfunction

  task automatic send(input vec_t v, input int unsigned tag);
    int k;
    @(posedge clk); #1;
    drive(v, tag);
    in_valid = 1'b1;
    for (k = 0; k < 50; k++) begin
      @(negedge clk);
      if (in_ready) break;
      @(posedge clk); #1;
    end
    check("send_accepted_in_time", longint'(k < 50), 1);
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic wait_out(output bit ok);
    ok = 0;
    for (int k = 0; k < 30; k++) begin
      if (out_valid) begin ok = 1; break; end
      @(posedge clk); #1;
    end
  endtask

  // Accept at edge N (FIFO empty, out_ready high); report k with out_valid first high after N+k.
  task automatic send_lat(input vec_t v, input int unsigned tag, output int lat);
    lat = -1;
    @(posedge clk); #1;
    drive(v, tag);
    in_valid = 1'b1;
    @(negedge clk);
    check("lat_in_ready", longint'(in_ready), 1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    for (int k = 1; k <= 20; k++) begin
      @(posedge clk); #1;
      if (out_valid) begin lat = k; break; end
    end
  endtask

  vec_t dir [12];
  vec_t bp  [12];

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bit ok;
    int lat, sent, n0, cyc;

    dir[0]  = '{1000, 500, 900, 400, 15, 'h0100, 15, 0};
    dir[1]  = '{1020, 500, 900, 400, 15, 'h0080, 3, 0};
    dir[2]  = '{1000, 400, 900, 400, 15, 'h0100, 0, 1};
    dir[3]  = '{1501, 500, 900, 400, 15, 'h0100, 0, 1};
    dir[4]  = '{5901, 5401, 900, 400, 15, 'h0100, 0, 1};
    dir[5]  = '{1500, 500, 900, 400, 15, 'h0100, -489, 0};
    dir[6]  = '{5900, 5400, 900, 400, 200, 'h0100, 200, 0};
    dir[7]  = '{800, 500, 900, 400, 15, 'h0100, 0, 1};
    dir[8]  = '{100, 0, 0, 'hFFFF_FFFF, 15, 'h0100, 0, 1};
    dir[9]  = '{905, 405, 900, 400, 100, 'h0100, 5, 0};
    dir[10] = '{911, 410, 900, 400, 20, 'h0200, 8, 0};
    dir[11] = '{954, 450, 900, 400, 8, 'h0000, 7, 0};

    // reset state
    repeat (3) @(posedge clk);
    #1;
    check("rst_in_ready", longint'(in_ready), 0);
    check("rst_out_valid", longint'(out_valid), 0);
    check("rst_out_score", longint'(out_score), 0);
    check("rst_out_reject", longint'(out_reject), 0);
    check("rst_out_tag", longint'(out_tag), 0);
    reset = 1'b0;
    @(negedge clk);
    check("in_ready_after_release", longint'(in_ready), 1);

    // directed vectors against hand-computed constants
    for (int i = 0; i < 12; i++) begin
      send(dir[i], 'h100 + i);
      wait_out(ok);
      check($sformatf("dir%0d_out_valid", i), longint'(ok), 1);
      if (ok) begin
        check($sformatf("dir%0d_score", i), longint'($signed(out_score)), longint'(dir[i].exp_score));
        check($sformatf("dir%0d_reject", i), longint'(out_reject), longint'(dir[i].exp_rej));
        check($sformatf("dir%0d_tag", i), longint'(out_tag), longint'('h100 + i));
      end
    end

    // zero-gap latency
    repeat (3) @(posedge clk);
    send_lat(dir[0], 'h150, lat);
    check("latency_zero_gap", lat, 6);

    // backpressure: 12 back-to-back pairs against a stalled consumer
    repeat (3) @(posedge clk);
    for (int i = 0; i < 12; i++) bp[i] = rnd_pair();
    #1;
    out_ready = 1'b0;
    n0 = n_out;
    sent = 0;
    for (int c = 0; c < 20; c++) begin
      @(posedge clk); #1;
      in_valid = (sent < 12);
      if (sent < 12) drive(bp[sent], 'h200 + sent);
      @(negedge clk);
      if (in_valid && in_ready) sent++;
    end
    check("bp_accepted_count", sent, 8);
    check("bp_in_ready_low", longint'(in_ready), 0);
    check("bp_out_valid", longint'(out_valid), 1);
    check("bp_no_pops", n_out - n0, 0);
    @(posedge clk); #1;
    out_ready = 1'b1;
    @(negedge clk);
    check("bp_no_credit_before_pop", longint'(in_ready), 0);
    @(posedge clk); #1;
    @(negedge clk);
    check("bp_credit_after_pop", longint'(in_ready), 1);
    if (in_valid && in_ready) sent++;
    for (cyc = 0; cyc < 100; cyc++) begin
      if (sent == 12 && exp_q.size() == 0 && !out_valid) break;
      @(posedge clk); #1;
      in_valid = (sent < 12);
      if (sent < 12) drive(bp[sent], 'h200 + sent);
      @(negedge clk);
      if (in_valid && in_ready) sent++;
    end
    check("bp_drain_in_time", longint'(cyc < 100), 1);
    check("bp_total_sent", sent, 12);
    check("bp_total_out", n_out - n0, 12);

    // random streaming with random backpressure
    n0 = n_out;
    sent = 0;
    for (cyc = 0; cyc < 3000; cyc++) begin
      if (sent == 100 && exp_q.size() == 0) break;
      @(posedge clk); #1;
      out_ready = ($urandom_range(0, 9) < 6);
      if (sent < 100 && $urandom_range(0, 9) < 7) begin
        drive(rnd_pair(), 'h1000 + sent);
        in_valid = 1'b1;
      end else in_valid = 1'b0;
      @(negedge clk);
      if (in_valid && in_ready) sent++;
    end
    #1;
    in_valid = 1'b0;
    out_ready = 1'b1;
    check("rnd_done_in_time", longint'(cyc < 3000), 1);
    check("rnd_sent", sent, 100);
    check("rnd_out_count", n_out - n0, 100);
    check("rnd_queue_empty", exp_q.size(), 0);

    // reset with 3 buffered and 5 in flight
    repeat (3) @(posedge clk);
    #1;
    out_ready = 1'b0;
    for (int j = 0; j < 3; j++) begin
      @(posedge clk); #1;
      drive(rnd_pair(), 'h300 + j);
      in_valid = 1'b1;
      @(negedge clk);
      check("rst_seq_buf_ready", longint'(in_ready), 1);
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    check("rst_seq_buffered", longint'(out_valid), 1);
    for (int j = 0; j < 5; j++) begin
      @(posedge clk); #1;
      drive(rnd_pair(), 'h310 + j);
      in_valid = 1'b1;
      @(negedge clk);
      check("rst_seq_flight_ready", longint'(in_ready), 1);
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    reset = 1'b1;
    #1;
    check("rst_seq_out_valid_drop", longint'(out_valid), 0);
    check("rst_seq_in_ready_drop", longint'(in_ready), 0);
    n0 = n_out;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    check("rst_seq_in_ready_release", longint'(in_ready), 1);
    check("rst_seq_out_valid_release", longint'(out_valid), 0);
    repeat (15) @(negedge clk);
    check("rst_seq_nothing_emitted", n_out - n0, 0);
    send_lat(dir[1], 'h350, lat);
    check("rst_seq_latency", lat, 6);
    check("rst_seq_score", longint'($signed(out_score)), 3);
    repeat (5) @(posedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
